// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI snooping bus: line states, bus ops and arbiter FSM states.
package mesi_pkg;

  typedef enum logic [1:0] {
    MesiI = 2'd0,
    MesiS = 2'd1,
    MesiM = 2'd2,
    MesiE = 2'd3
  } mesi_state_e;

  typedef enum logic [1:0] {
    OpRdMiss = 2'd0,
    OpWrMiss = 2'd1,
    OpInv    = 2'd2,
    OpWb     = 2'd3
  } bus_op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StBcast = 3'd1,
    StSnoop = 3'd2,
    StMem   = 3'd3,
    StResp  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mesi_rr_arbiter.sv
// Combinational round-robin pick: first set req bit scanning upward from last_grant+1.
module mesi_rr_arbiter #(
  parameter int unsigned NPROC = 3
) (
  input  logic [NPROC-1:0] req,
  input  logic [1:0]       last_grant,
  output logic [1:0]       winner,
  output logic             valid
);

  int unsigned idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= int'(NPROC); i++) begin
      idx = (int'(last_grant) + i) % NPROC;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Shared-bus controller: round-robin grant, snoop broadcast, memory access and response.
module mesi_bus_arbiter
  import mesi_pkg::*;
#(
  parameter int unsigned NPROC  = 3,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NPROC-1:0]          req,
  input  logic [2*NPROC-1:0]        req_op,
  input  logic [ADDR_W*NPROC-1:0]   req_addr,
  input  logic [DATA_W*NPROC-1:0]   req_data,
  output logic [NPROC-1:0]          ack,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_share,
  output logic                      bus_valid,
  output logic [1:0]                bus_op,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [1:0]                bus_src,
  input  logic [NPROC-1:0]          snoop_share,
  input  logic [NPROC-1:0]          snoop_wb,
  input  logic [DATA_W*NPROC-1:0]   snoop_data,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ready
);

  arb_state_e        state;
  logic [1:0]        last_grant;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] fill_q;
  logic              share_q;

  logic [1:0]        winner;
  logic              win_valid;

  logic [NPROC-1:0]  mask;
  logic [NPROC-1:0]  wb_m;
  logic [NPROC-1:0]  src_onehot;
  logic              share_now;
  logic [1:0]        owner;
  logic              owner_valid;
  logic [DATA_W-1:0] owner_data;

  mesi_rr_arbiter #(
    .NPROC(NPROC)
  ) u_rr (
    .req       (req),
    .last_grant(last_grant),
    .winner    (winner),
    .valid     (win_valid)
  );

  // bus_src doubles as the latched requester index for the whole transaction.
  always_comb begin
    mask       = '0;
    src_onehot = '0;
    for (int i = 0; i < int'(NPROC); i++) begin
      mask[i]       = (i != int'(bus_src));
      src_onehot[i] = (i == int'(bus_src));
    end
    wb_m        = snoop_wb & mask;
    share_now   = |((snoop_share | snoop_wb) & mask);
    owner       = '0;
    owner_valid = 1'b0;
    for (int i = int'(NPROC) - 1; i >= 0; i--) begin
      if (wb_m[i]) begin
        owner_valid = 1'b1;
        owner       = 2'(i);
      end
    end
    owner_data = snoop_data[int'(owner)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      last_grant <= 2'(NPROC - 1);
      wdata_q    <= '0;
      fill_q     <= '0;
      share_q    <= 1'b0;
      ack        <= '0;
      rsp_data   <= '0;
      rsp_share  <= 1'b0;
      bus_valid  <= 1'b0;
      bus_op     <= '0;
      bus_addr   <= '0;
      bus_src    <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      bus_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (win_valid) begin
            bus_op    <= req_op[int'(winner)*2 +: 2];
            bus_addr  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
            wdata_q   <= req_data[int'(winner)*DATA_W +: DATA_W];
            bus_src   <= winner;
            bus_valid <= 1'b1;
            fill_q    <= '0;
            state     <= StBcast;
          end
        end
        StBcast: state <= StSnoop;
        StSnoop: begin
          share_q <= share_now;
          unique case (bus_op_e'(bus_op))
            OpRdMiss: begin
              mem_addr <= bus_addr;
              state    <= StMem;
              if (owner_valid) begin
                fill_q    <= owner_data;
                mem_wr    <= 1'b1;
                mem_wdata <= owner_data;
              end else begin
                mem_rd <= 1'b1;
              end
            end
            OpWrMiss: begin
              if (owner_valid) begin
                fill_q    <= owner_data;
                mem_wr    <= 1'b1;
                mem_wdata <= owner_data;
                mem_addr  <= bus_addr;
                state     <= StMem;
              end else begin
                ack       <= src_onehot;
                rsp_data  <= '0;
                rsp_share <= share_now;
                state     <= StResp;
              end
            end
            OpInv: begin
              ack       <= src_onehot;
              rsp_data  <= '0;
              rsp_share <= share_now;
              state     <= StResp;
            end
            OpWb: begin
              mem_wr    <= 1'b1;
              mem_wdata <= wdata_q;
              mem_addr  <= bus_addr;
              state     <= StMem;
            end
          endcase
        end
        StMem: begin
          if (mem_ready) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack       <= src_onehot;
            rsp_share <= share_q;
            rsp_data  <= mem_rd ? mem_rdata : fill_q;
            state     <= StResp;
          end
        end
        StResp: begin
          ack        <= '0;
          rsp_data   <= '0;
          rsp_share  <= 1'b0;
          last_grant <= bus_src;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Self-checking bench: vector table of single transactions plus round-robin and reset sequences.
module tb_mesi_bus_arbiter;

  localparam int NPROC  = 3;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic                    clock;
  logic                    reset_n;
  logic [NPROC-1:0]        req;
  logic [2*NPROC-1:0]      req_op;
  logic [ADDR_W*NPROC-1:0] req_addr;
  logic [DATA_W*NPROC-1:0] req_data;
  logic [NPROC-1:0]        ack;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_share;
  logic                    bus_valid;
  logic [1:0]              bus_op;
  logic [ADDR_W-1:0]       bus_addr;
  logic [1:0]              bus_src;
  logic [NPROC-1:0]        snoop_share;
  logic [NPROC-1:0]        snoop_wb;
  logic [DATA_W*NPROC-1:0] snoop_data;
  logic                    mem_rd;
  logic                    mem_wr;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    mem_ready;

  mesi_bus_arbiter #(
    .NPROC (NPROC),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .ack        (ack),
    .rsp_data   (rsp_data),
    .rsp_share  (rsp_share),
    .bus_valid  (bus_valid),
    .bus_op     (bus_op),
    .bus_addr   (bus_addr),
    .bus_src    (bus_src),
    .snoop_share(snoop_share),
    .snoop_wb   (snoop_wb),
    .snoop_data (snoop_data),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] ack;
    logic [7:0] data;
    logic       share;
  } exp_t;

  // exp_mem: 0 none, 1 read, 2 write; exp_lat counts cycles from the IDLE sampling edge.
  typedef struct {
    logic [1:0]  src;
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [7:0]  wdata;
    logic [2:0]  share;
    logic [2:0]  wb;
    logic [23:0] sdata;
    logic [7:0]  rdata;
    int          delay;
    logic [1:0]  exp_mem;
    logic [4:0]  exp_maddr;
    logic [7:0]  exp_mwd;
    logic [2:0]  exp_ack;
    logic [7:0]  exp_data;
    logic        exp_share;
    int          exp_lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {27'b0, ack, rsp_data, rsp_share, bus_valid, bus_op, bus_addr, bus_src,
            mem_rd, mem_wr, mem_addr, mem_wdata};
  endfunction

  // Scoreboard: every ack pops the oldest expected response.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (mem_rd && mem_wr) begin
        n_bad++;
        $display("FAIL mem_excl: mem_rd and mem_wr both high");
      end
      if (!$onehot0(ack)) begin
        n_bad++;
        $display("FAIL ack_onehot: got %b", ack);
      end
      if (ack != '0) begin
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_ack: got %b expected none", ack);
        end else begin
          e = sb.pop_front();
          check("ack", 64'(ack), 64'(e.ack));
          check("rsp_data", 64'(rsp_data), 64'(e.data));
          check("rsp_share", 64'(rsp_share), 64'(e.share));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int k = 0;
    int memcyc = 0;
    bit acked = 0;
    int s = int'(v.src);
    @(negedge clock);
    req = '0;
    req[s] = 1'b1;
    req_op[2*s +: 2]   = v.op;
    req_addr[5*s +: 5] = v.addr;
    req_data[8*s +: 8] = v.wdata;
    snoop_share = v.share;
    snoop_wb    = v.wb;
    snoop_data  = v.sdata;
    mem_rdata   = v.rdata;
    mem_ready   = 1'b0;
    sb.push_back('{v.exp_ack, v.exp_data, v.exp_share});
    while (!acked && k < 40) begin
      @(negedge clock);
      k++;
      if (k == 1)
        check($sformatf("bus[%0d]", idx), 64'({bus_valid, bus_op, bus_addr, bus_src}),
              64'({1'b1, v.op, v.addr, v.src}));
      if (mem_rd || mem_wr) begin
        memcyc++;
        check($sformatf("mem[%0d]", idx), 64'({mem_rd, mem_wr, mem_addr, mem_wdata}),
              64'({v.exp_mem == 2'd1, v.exp_mem == 2'd2, v.exp_maddr, v.exp_mwd}));
        mem_ready = (memcyc > v.delay);
      end else begin
        mem_ready = 1'b0;
      end
      if (ack != '0) begin
        acked = 1;
        check($sformatf("latency[%0d]", idx), 64'(k), 64'(v.exp_lat));
        req = '0;
        mem_ready = 1'b0;
      end
    end
    if (!acked) begin
      n_bad++;
      $display("FAIL timeout[%0d]: no ack within 40 cycles", idx);
    end
  endtask

  // Invalidates from several requesters; rereq[3*i +: 3] is raised after the i-th ack.
  task automatic inv_group(input string name, input logic [2:0] start, input logic [11:0] order,
                           input int nack, input logic [11:0] rereq);
    int k = 0;
    int got = 0;
    @(negedge clock);
    req_op      = 6'b101010;
    snoop_share = '0;
    snoop_wb    = '0;
    mem_ready   = 1'b0;
    for (int i = 0; i < nack; i++) sb.push_back('{order[3*i +: 3], 8'h00, 1'b0});
    req = start;
    while (got < nack && k < 80) begin
      @(negedge clock);
      k++;
      if (ack != '0) begin
        check($sformatf("%s_lat%0d", name, got), 64'(k), 64'(3 + 4*got));
        req = (req & ~ack) | rereq[3*got +: 3];
        got++;
      end
    end
    if (got < nack) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d acks expected %0d", name, got, nack);
    end
    req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n = 1'b0;
    req = '0; req_op = '0; req_addr = '0; req_data = '0;
    snoop_share = '0; snoop_wb = '0; snoop_data = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    //            src   op    addr   wdat   shr     wb      sdata       rdat   dly mem   maddr  mwd    ack     data   sh    lat
    vecs[0] = '{2'd1, 2'd0, 5'h0A, 8'h00, 3'b000, 3'b000, 24'h000000, 8'h3C, 2, 2'd1, 5'h0A, 8'h00, 3'b010, 8'h3C, 1'b0, 6};
    vecs[1] = '{2'd0, 2'd0, 5'h04, 8'h00, 3'b000, 3'b100, 24'h770000, 8'hEE, 0, 2'd2, 5'h04, 8'h77, 3'b001, 8'h77, 1'b1, 4};
    vecs[2] = '{2'd2, 2'd2, 5'h07, 8'h00, 3'b101, 3'b000, 24'h000000, 8'h00, 0, 2'd0, 5'h00, 8'h00, 3'b100, 8'h00, 1'b1, 3};
    vecs[3] = '{2'd2, 2'd2, 5'h08, 8'h00, 3'b100, 3'b000, 24'h000000, 8'h00, 0, 2'd0, 5'h00, 8'h00, 3'b100, 8'h00, 1'b0, 3};
    vecs[4] = '{2'd1, 2'd1, 5'h11, 8'h00, 3'b001, 3'b000, 24'h000000, 8'h00, 0, 2'd0, 5'h00, 8'h00, 3'b010, 8'h00, 1'b1, 3};
    vecs[5] = '{2'd1, 2'd1, 5'h12, 8'h00, 3'b000, 3'b011, 24'h005566, 8'h00, 1, 2'd2, 5'h12, 8'h66, 3'b010, 8'h66, 1'b1, 5};
    vecs[6] = '{2'd0, 2'd3, 5'h1F, 8'hA5, 3'b010, 3'b000, 24'h000000, 8'h00, 0, 2'd2, 5'h1F, 8'hA5, 3'b001, 8'h00, 1'b1, 4};
    vecs[7] = '{2'd2, 2'd0, 5'h03, 8'h00, 3'b000, 3'b011, 24'h998844, 8'h00, 0, 2'd2, 5'h03, 8'h44, 3'b100, 8'h44, 1'b1, 4};
    vecs[8] = '{2'd0, 2'd0, 5'h1E, 8'h00, 3'b000, 3'b001, 24'h000000, 8'hE1, 1, 2'd1, 5'h1E, 8'h00, 3'b001, 8'hE1, 1'b0, 5};

    repeat (2) @(negedge clock);
    check("reset_outputs", outs(), 64'h0);
    reset_n = 1'b1;

    // Round robin from reset: 0,1,2, then 0 again after it re-requests.
    inv_group("rr", 3'b111, {3'b000, 3'b001, 3'b100, 3'b010, 3'b001}, 4,
              {3'b000, 3'b000, 3'b001, 3'b000, 3'b000});

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Write-back abandoned by reset mid-access.
    @(negedge clock);
    req = 3'b001;
    req_op[1:0] = 2'd3;
    req_addr[4:0] = 5'h1F;
    req_data[7:0] = 8'hA5;
    snoop_share = '0; snoop_wb = '0;
    mem_ready = 1'b0;
    k = 0;
    while (!mem_wr && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("abort_mem", 64'({mem_wr, mem_addr, mem_wdata}), 64'({1'b1, 5'h1F, 8'hA5}));
    #2 reset_n = 1'b0;
    #1 check("abort_outputs", outs(), 64'h0);
    @(negedge clock);
    req = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("abort_no_ack", 64'(sb.size()), 64'(0));

    // After reset processor 0 is first again even though 1 also requests.
    inv_group("prio", 3'b011, {3'b000, 3'b000, 3'b000, 3'b010, 3'b001}, 2, 12'h000);

    repeat (3) @(negedge clock);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mesi_bus_arbiter.md
# mesi_bus_arbiter

- Shared-bus controller sitting directly upstream of every cache's snooping MESI machine.
- Accepts bus requests from the processors (read miss, write miss, invalidate, write-back) and grants them round-robin, one transaction at a time.
- Broadcasts the granted transaction to all snoopers and collects their share and write-back responses.
- Performs the shared-memory access, unless a snooper supplies the data, then returns data and the share flag to the requester.

## Interface
Parameters:
- NPROC, 3, number of processors; legal range 2..4.
- ADDR_W, 5, address width.
- DATA_W, 8, data width.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  NPROC  per-processor request; held until that processor's ack
- req_op  in  2*NPROC  per-processor op: 0 read miss, 1 write miss, 2 invalidate, 3 write-back
- req_addr  in  ADDR_W*NPROC  per-processor address
- req_data  in  DATA_W*NPROC  per-processor write-back data
- ack  out  NPROC  one-cycle completion pulse to the granted processor
- rsp_data  out  DATA_W  fill data; valid only while ack is high
- rsp_share  out  1  another cache holds the line; valid only while ack is high
- bus_valid  out  1  broadcast strobe to snoopers
- bus_op  out  2  broadcast op
- bus_addr  out  ADDR_W  broadcast address
- bus_src  out  2  index of the granted processor
- snoop_share  in  NPROC  snooper holds the line in S or E
- snoop_wb  in  NPROC  snooper holds the line in M and aborts memory
- snoop_data  in  DATA_W*NPROC  snooper's dirty data
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory access complete

## Operation
FSM states: IDLE, BCAST, SNOOP, MEM, RESP.
- IDLE: if any req bit is set, latch the winner's op, addr and data plus the winner index, then go to BCAST.
  - Winner = first set bit scanning from (last_grant+1) mod NPROC.
  - last_grant resets to NPROC-1, so processor 0 has first priority.
- BCAST: bus_valid=1 for exactly one cycle with bus_op, bus_addr and bus_src. Go to SNOOP.
- SNOOP: sample snoop_share and snoop_wb, masked by ~(1<<src). The requester's own responses are always ignored.
  - owner = lowest-index masked snoop_wb bit.
  - Read miss, owner present: fill data = snoop_data[owner]; go to MEM with mem_wr of that data (write-back).
  - Read miss, no owner: go to MEM with mem_rd.
  - Write miss: with owner, go to MEM with mem_wr of the owner's data; otherwise go to RESP.
  - Invalidate: go to RESP with no memory access.
  - Write-back op: go to MEM with mem_wr of the latched req_data.
- MEM: hold mem_rd or mem_wr, mem_addr and mem_wdata constant until mem_ready is sampled high.
  - On a read, capture mem_rdata as fill data.
  - Then go to RESP.
- RESP: ack[src]=1 and rsp_data = fill data (0 for invalidate, write-back, and write miss without owner).
  - rsp_share = |((snoop_share|snoop_wb) & mask), as sampled in SNOOP.
  - Update last_grant=src, then go to IDLE.
- Requester clears req on the edge that ends its ack cycle; a req still high in IDLE is treated as a new transaction.
- At most one of mem_rd and mem_wr is ever high; at most one ack bit is ever high.
- req changes between grant and ack are ignored; fields are latched in IDLE.

## Timing
- Reset (async, any state) forces:
  - state IDLE and last_grant NPROC-1.
  - All outputs 0: ack, rsp_data, rsp_share, bus_valid, bus_op, bus_addr, bus_src, mem_rd, mem_wr, mem_addr, mem_wdata.
  - An in-flight memory access is abandoned with no ack.
- Request sampled at edge 0 gives bus_valid during cycle 1 and SNOOP during cycle 2.
- ack timing:
  - Invalidate, or write miss without owner: ack in cycle 3.
  - With memory access: ack in the cycle after mem_ready is sampled; if mem_ready is already high in the first MEM cycle, ack is in cycle 4.
- mem_ready high outside MEM is ignored.
- Back-to-back: the next grant can be sampled in the IDLE cycle immediately after RESP.
- Minimum spacing between bus_valid strobes is 4 cycles.

## Structure
- mesi_pkg holds the shared typedefs and constants:
  - MESI state encoding: I=0, S=1, M=2, E=3.
  - Bus op encoding: RD_MISS=0, WR_MISS=1, INV=2, WB=3.
  - Arbiter FSM state typedef.
- One sub-module, mesi_rr_arbiter: combinational round-robin pick from the req vector and last_grant, producing a winner index and a valid flag.
- Everything else (datapath latches and FSM) lives in mesi_bus_arbiter.

## Test plan
- Reset, then processor 1 read miss at addr 5'h0A, no snoop responses, mem_rdata=8'h3C with mem_ready 2 cycles late -> mem_rd addr 0A; ack=3'b010, rsp_data=3C, rsp_share=0.
- Processor 0 read miss at 5'h04 while snoop_wb[2]=1, snoop_data[2]=8'h77 -> mem_wr addr 04 data 77, no mem_rd; ack[0] with rsp_data=77, rsp_share=1.
- req=3'b111 held, each requester dropping req after its ack, all invalidates -> grants in order 0,1,2, then 0 again on re-request; each ack 3 cycles after its IDLE sample.
- Processor 2 invalidate with snoop_share[2]=1 and snoop_share[0]=1 -> own response masked; rsp_share=1, no memory access, ack[2] in cycle 3.
- Processor 0 write-back op with data 8'hA5 at 5'h1F, reset_n pulsed low during MEM -> all outputs 0 immediately, no ack; after release processor 0 again has first priority.
